// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 port sequencer.
//   cmd_t    : calc2_top command encodings
//   resp_t   : response codes on the calc2_top port and on the result output
//   state_t  : issue FSM states
//   result_t : one result-queue entry {resp, data, tag}
//   lowest_tag() : index of the lowest set bit of a tag vector (0 if none set)
package calc2_pkg;

  localparam int unsigned TAG_W    = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_TAGS = 1 << TAG_W;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2,
    TMO  = 2'd3
  } resp_t;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StSendOp2 = 1'b1
  } state_t;

  typedef struct packed {
    resp_t             resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } result_t;

  function automatic logic [TAG_W-1:0] lowest_tag(input logic [NUM_TAGS-1:0] vec);
    lowest_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_tag = TAG_W'(i);
    end
  endfunction

endpackage

// File: rtl/calc2_port_sequencer_if.sv
// Signal bundle between the sequencer and its environment.
//   op_*       : operation handshake into the sequencer
//   req_*_out  : request lines towards one calc2_top port
//   out_*      : response lines from that calc2_top port
//   res_*      : result handshake out of the sequencer
//   err_spurious : pulse on an unexpected response
// Modports: slave is the sequencer; master is the environment that feeds operations,
// plays the calc2_top port and consumes results.
interface calc2_port_sequencer_if;
  import calc2_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_cmd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic [3:0]        req_cmd_out;
  logic [DATA_W-1:0] req_data_out;
  logic [TAG_W-1:0]  req_tag_out;

  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_resp;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;

  logic              err_spurious;

  modport master (
    output op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag, res_ready,
    input  op_ready, req_cmd_out, req_data_out, req_tag_out,
    input  res_valid, res_resp, res_data, res_tag, err_spurious
  );

  modport slave (
    input  op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag, res_ready,
    output op_ready, req_cmd_out, req_data_out, req_tag_out,
    output res_valid, res_resp, res_data, res_tag, err_spurious
  );

endinterface

// File: rtl/calc2_result_fifo.sv
// Result queue: circular-buffer FIFO with registered count.
//   c_clk, reset : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored when full and not popping)
//   pop, pop_data   : head entry; pop_data reads 0 while empty
//   empty           : no entries held
module calc2_result_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A full queue may still accept a push in the same cycle as a pop.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge c_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/calc2_port_sequencer.sv
// Drives one calc2_top port: accepts an operation, issues it over two cycles
// (cmd + op_a with a tag, then op_b), tracks outstanding tags with age counters,
// and queues responses or timeouts as results.
//   c_clk, reset : clock, asynchronous active-low reset
//   bus (slave)  : op_* handshake in, req_*_out to the port, out_* from the port,
//                  res_* result handshake out, err_spurious pulse
// Parameters: TIMEOUT cycles before an outstanding tag is retired, RQ_DEPTH result
// queue depth (equal to the tag count so the queue cannot overflow).
module calc2_port_sequencer
  import calc2_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned RQ_DEPTH = NUM_TAGS
) (
  input logic                    c_clk,
  input logic                    reset,
  calc2_port_sequencer_if.slave  bus
);

  localparam int unsigned     AgeW   = $clog2(TIMEOUT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(TIMEOUT);

  state_t              state_q, state_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [AgeW-1:0]     age_q [NUM_TAGS];
  logic [AgeW-1:0]     age_d [NUM_TAGS];
  logic [DATA_W-1:0]   op_b_q, op_b_d;

  logic [NUM_TAGS-1:0] saturated;
  logic [TAG_W-1:0]    alloc_tag, tmo_tag;
  logic                ready_int, accept;
  resp_t               port_resp;
  logic                resp_hit, resp_ok, tmo_fire;
  result_t             push_rec, head;
  logic                fifo_push, fifo_pop, fifo_empty;
  logic [$bits(result_t)-1:0] head_bits;

  // Handshake; every output is forced low while reset is asserted.
  assign alloc_tag    = lowest_tag(~busy_q);
  assign ready_int    = (state_q == StIdle) && (busy_q != '1);
  assign bus.op_ready = reset & ready_int;
  assign accept       = bus.op_ready & bus.op_valid;

  // A response only counts on a busy tag; TMO from the port is never a legal response.
  assign port_resp        = resp_t'(bus.out_resp);
  assign resp_hit         = (port_resp != NONE);
  assign resp_ok          = resp_hit && (port_resp != TMO) && busy_q[bus.out_tag];
  assign bus.err_spurious = reset & resp_hit & ~resp_ok;

  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      saturated[i] = busy_q[i] && (age_q[i] == AgeMax);
    end
  end

  // Timeout retirement yields to a response push: one queue write per cycle.
  assign tmo_tag  = lowest_tag(saturated);
  assign tmo_fire = (|saturated) & ~resp_ok;

  always_comb begin
    if (resp_ok) begin
      push_rec = '{resp: port_resp, data: bus.out_data, tag: bus.out_tag};
    end else begin
      push_rec = '{resp: TMO, data: '0, tag: tmo_tag};
    end
  end

  assign fifo_push = resp_ok | tmo_fire;
  assign fifo_pop  = bus.res_valid & bus.res_ready;

  // Tag pool: frees take effect at the edge, so a freed tag is allocatable next cycle.
  always_comb begin
    busy_d = busy_q;
    if (resp_ok)  busy_d[bus.out_tag] = 1'b0;
    if (tmo_fire) busy_d[tmo_tag]     = 1'b0;
    if (accept)   busy_d[alloc_tag]   = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      age_d[i] = age_q[i];
      if (accept && (alloc_tag == TAG_W'(i))) begin
        age_d[i] = '0;
      end else if (busy_q[i] && (age_q[i] != AgeMax)) begin
        age_d[i] = age_q[i] + AgeW'(1);
      end
    end
  end

  assign op_b_d = accept ? bus.op_b : op_b_q;

  // Issue FSM: next state and port request lines.
  always_comb begin
    state_d          = state_q;
    bus.req_cmd_out  = '0;
    bus.req_data_out = '0;
    bus.req_tag_out  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d          = StSendOp2;
          bus.req_cmd_out  = bus.op_cmd;
          bus.req_data_out = bus.op_a;
          bus.req_tag_out  = alloc_tag;
        end
      end
      StSendOp2: begin
        state_d          = StIdle;
        bus.req_data_out = op_b_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      busy_q  <= '0;
      op_b_q  <= '0;
      for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      op_b_q  <= op_b_d;
      for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= age_d[i];
    end
  end

  calc2_result_fifo #(
    .Depth (RQ_DEPTH),
    .Width ($bits(result_t))
  ) u_result_fifo (
    .c_clk     (c_clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .empty     (fifo_empty)
  );

  assign head          = result_t'(head_bits);
  assign bus.res_valid = ~fifo_empty;
  assign bus.res_resp  = head.resp;
  assign bus.res_data  = head.data;
  assign bus.res_tag   = head.tag;

endmodule

// File: tb/tb_calc2_port_sequencer.sv
// Bench for calc2_port_sequencer: table of single operations plus hand sequences for
// tag exhaustion, out-of-order completion, timeout, spurious responses and reset mid-issue.
// Expected results go into a scoreboard queue when the port response is driven and are
// compared as the DUT hands results out.
module tb_calc2_port_sequencer;
  import calc2_pkg::*;

  logic c_clk = 1'b0;
  logic reset = 1'b0;

  calc2_port_sequencer_if bus ();

  calc2_port_sequencer #(
    .TIMEOUT  (64),
    .RQ_DEPTH (4)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  result_t sb_q[$];
  result_t exp_r;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Result monitor: every handed-out result must match the oldest expectation.
  always @(negedge c_clk) begin
    if (reset && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, want none",
                 {bus.res_resp, bus.res_data, bus.res_tag});
      end else begin
        exp_r = sb_q.pop_front();
        check("result", 64'({bus.res_resp, bus.res_data, bus.res_tag}), 64'(exp_r));
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.op_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.op_ready) check(name, 64'(bus.op_ready), 64'(1));
  endtask

  // Issue one operation; returns at the start of the cycle after SEND_OP2.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] exp_tag);
    wait_ready("issue_ready_timeout");
    bus.op_valid = 1'b1;
    bus.op_cmd   = cmd;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge c_clk);
    check("op1_ready", 64'(bus.op_ready), 64'(1));
    check("op1_req", 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out}),
          64'({cmd, a, exp_tag}));
    tick();
    bus.op_valid = 1'b0;
    @(negedge c_clk);
    check("op2_req", 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out}),
          64'({4'd0, b, 2'd0}));
    check("op2_not_ready", 64'(bus.op_ready), 64'(0));
    tick();
  endtask

  // Drive a one-cycle port response; push expectation when it should be queued.
  task automatic respond(input logic [1:0] tag, input logic [1:0] resp,
                         input logic [31:0] data, input bit push);
    result_t r;
    bus.out_resp = resp;
    bus.out_tag  = tag;
    bus.out_data = data;
    if (push) begin
      r.resp = resp_t'(resp);
      r.data = data;
      r.tag  = tag;
      sb_q.push_back(r);
    end
    @(negedge c_clk);
    check("err_spurious", 64'(bus.err_spurious), 64'(!push));
    tick();
    bus.out_resp = 2'd0;
    bus.out_tag  = 2'd0;
    bus.out_data = 32'd0;
  endtask

  initial begin
    int cyc;
    result_t r;

    vecs[0] = '{cmd: 4'd1, a: 32'h22,        b: 32'h3,        resp: 2'b01, rdata: 32'h25};
    vecs[1] = '{cmd: 4'd2, a: 32'h100,       b: 32'h1,        resp: 2'b01, rdata: 32'hFF};
    vecs[2] = '{cmd: 4'd5, a: 32'h1,         b: 32'h4,        resp: 2'b01, rdata: 32'h10};
    vecs[3] = '{cmd: 4'd6, a: 32'h8000_0000, b: 32'd31,       resp: 2'b01, rdata: 32'h1};
    vecs[4] = '{cmd: 4'hF, a: 32'hDEAD_BEEF, b: 32'h1234_5678, resp: 2'b10, rdata: 32'h0};
    vecs[5] = '{cmd: 4'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, resp: 2'b10, rdata: 32'hA5A5};

    bus.op_valid  = 1'b1;
    bus.op_cmd    = 4'd1;
    bus.op_a      = 32'h5;
    bus.op_b      = 32'h6;
    bus.out_resp  = 2'b01;
    bus.out_tag   = 2'd1;
    bus.out_data  = 32'h7;
    bus.res_ready = 1'b1;

    // Reset: everything low even with live inputs.
    tick();
    @(negedge c_clk);
    check("rst_op_ready", 64'(bus.op_ready), 64'(0));
    check("rst_req", 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out}), 64'(0));
    check("rst_res", 64'({bus.res_valid, bus.res_resp, bus.res_data, bus.res_tag}), 64'(0));
    check("rst_err", 64'(bus.err_spurious), 64'(0));
    tick();
    bus.op_valid = 1'b0;
    bus.out_resp = 2'd0;
    bus.out_tag  = 2'd0;
    bus.out_data = 32'd0;
    reset        = 1'b1;
    @(negedge c_clk);
    check("ready_after_reset", 64'(bus.op_ready), 64'(1));
    tick();

    // Table of single operations, each completed on tag 0.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].cmd, vecs[i].a, vecs[i].b, 2'd0);
      @(negedge c_clk);
      check("idle_req_zero", 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out}),
            64'(0));
      tick();
      respond(2'd0, vecs[i].resp, vecs[i].rdata, 1'b1);
      tick();
      tick();
    end

    // Fill all four tags back to back with op_valid held high.
    bus.op_valid = 1'b1;
    bus.op_cmd   = 4'd1;
    for (int c = 0; c < 8; c++) begin
      bus.op_a = 32'h100 + 32'(c);
      bus.op_b = 32'h200 + 32'(c);
      @(negedge c_clk);
      if (c % 2 == 0) begin
        check("fill_ready", 64'(bus.op_ready), 64'(1));
        check("fill_tag", 64'({bus.req_cmd_out, bus.req_tag_out}), 64'({4'd1, 2'(c / 2)}));
      end else begin
        check("fill_busy", 64'(bus.op_ready), 64'(0));
        check("fill_op2", 64'(bus.req_data_out), 64'(32'h200 + 32'(c - 1)));
      end
      tick();
    end
    @(negedge c_clk);
    check("ready_tags_full", 64'(bus.op_ready), 64'(0));
    tick();

    // Response frees tag 2; it is reusable only from the next cycle.
    bus.out_resp = 2'b01;
    bus.out_tag  = 2'd2;
    bus.out_data = 32'h77;
    r = '{resp: OK, data: 32'h77, tag: 2'd2};
    sb_q.push_back(r);
    @(negedge c_clk);
    check("ready_same_cycle_free", 64'(bus.op_ready), 64'(0));
    tick();
    bus.out_resp = 2'd0;
    bus.out_tag  = 2'd0;
    bus.out_data = 32'd0;
    @(negedge c_clk);
    check("realloc_tag2", 64'({bus.op_ready, bus.req_tag_out}), 64'({1'b1, 2'd2}));
    tick();
    bus.op_valid = 1'b0;
    tick();

    // Out-of-order completion held back by res_ready, then drained in arrival order.
    bus.res_ready = 1'b0;
    respond(2'd3, 2'b01, 32'h303, 1'b1);
    respond(2'd1, 2'b01, 32'h301, 1'b1);
    respond(2'd0, 2'b10, 32'h300, 1'b1);
    respond(2'd2, 2'b01, 32'h302, 1'b1);
    @(negedge c_clk);
    check("held_head", 64'({bus.res_valid, bus.res_resp, bus.res_data, bus.res_tag}),
          64'({1'b1, 2'b01, 32'h303, 2'd3}));
    tick();
    bus.res_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("drain_done", 64'(sb_q.size()), 64'(0));
    @(negedge c_clk);
    check("drained_empty", 64'(bus.res_valid), 64'(0));
    tick();

    // Response on a free tag.
    respond(2'd1, 2'b01, 32'h55, 1'b0);
    @(negedge c_clk);
    check("spurious_one_cycle", 64'({bus.err_spurious, bus.res_valid}), 64'(0));
    tick();

    // TMO code from the port on a busy tag is spurious; tag stays busy.
    issue(4'd2, 32'h9, 32'h1, 2'd0);
    respond(2'd0, 2'b11, 32'h99, 1'b0);
    respond(2'd0, 2'b01, 32'h8, 1'b1);
    tick();

    // Timeout on tag 0, then a late response on it.
    wait_ready("tmo_ready_timeout");
    bus.op_valid = 1'b1;
    bus.op_cmd   = 4'd5;
    bus.op_a     = 32'h3;
    bus.op_b     = 32'h2;
    r = '{resp: TMO, data: 32'd0, tag: 2'd0};
    sb_q.push_back(r);
    @(negedge c_clk);
    check("tmo_issue_tag", 64'({bus.op_ready, bus.req_tag_out}), 64'({1'b1, 2'd0}));
    tick();
    bus.op_valid = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      @(negedge c_clk);
      if (bus.res_valid) break;
      tick();
      cyc++;
    end
    check("tmo_latency", 64'(cyc), 64'(66));
    tick();
    respond(2'd0, 2'b01, 32'h1234, 1'b0);
    tick();
    @(negedge c_clk);
    check("late_resp_no_result", 64'(bus.res_valid), 64'(0));
    tick();

    // Reset during SEND_OP2 drops the in-flight operation.
    wait_ready("rst_mid_ready_timeout");
    bus.op_valid = 1'b1;
    bus.op_cmd   = 4'd1;
    bus.op_a     = 32'hAA;
    bus.op_b     = 32'hBB;
    tick();
    bus.op_valid = 1'b0;
    @(negedge c_clk);
    check("mid_op2_data", 64'(bus.req_data_out), 64'(32'hBB));
    reset = 1'b0;
    #1;
    check("mid_rst_req", 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out}), 64'(0));
    check("mid_rst_ready", 64'({bus.op_ready, bus.res_valid, bus.err_spurious}), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    @(negedge c_clk);
    check("mid_rst_release_ready", 64'(bus.op_ready), 64'(1));
    tick();
    issue(4'd1, 32'h1, 32'h2, 2'd0);
    respond(2'd0, 2'b01, 32'h3, 1'b1);
    tick();
    tick();
    tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc2_port_sequencer.md
CALC2_PORT_SEQUENCER -- requirements
Module: calc2_port_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles an issued tag may wait for a response before it is retired as timed out.
REQ-002 Parameter RQ_DEPTH, default 4: result queue depth; fixed equal to tag count.
REQ-003 c_clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op_valid/op_ready  in/out  1/1  operation handshake; transfer when both high.
REQ-006 op_cmd  in  4  command: 1 add, 2 sub, 5 shl, 6 shr.
REQ-007 op_a, op_b  in  32/32  operand 1 and operand 2.
REQ-008 req_cmd_out, req_data_out, req_tag_out  out  4/32/2  drive one calc2_top port (reqN_cmd_in/data_in/tag_in).
REQ-009 out_resp, out_data, out_tag  in  2/32/2  from the same calc2_top port.
REQ-010 res_valid/res_ready  out/in  1/1  result handshake.
REQ-011 res_resp, res_data, res_tag  out  2/32/2  result; res_resp 01 ok, 10 error, 11 timeout.
REQ-012 err_spurious  out  1  one-cycle pulse on an unexpected response.

Function
REQ-013 FSM states IDLE and SEND_OP2; IDLE -> SEND_OP2 on accept; SEND_OP2 -> IDLE unconditionally.
REQ-014 op_ready SHALL be high only in IDLE with at least one free tag, evaluated from registered state.
REQ-015 On accept in cycle N, cycle N SHALL drive req_cmd_out=op_cmd, req_data_out=op_a, req_tag_out=allocated tag.
REQ-016 Cycle N+1 SHALL drive req_cmd_out=0, req_data_out=registered op_b, req_tag_out=0.
REQ-017 When not issuing, req_cmd_out, req_data_out and req_tag_out SHALL be 0; back-to-back issues occupy cycles N, N+2, ...
REQ-018 Allocation SHALL take the lowest-numbered free tag; the tag becomes busy and its age counter clears.
REQ-019 Commands outside {1,2,5,6} SHALL be forwarded unchanged; there is no local validity check.
REQ-020 A response (out_resp != 0) on a busy tag SHALL push {out_resp, out_data, out_tag} into the result queue and free the tag at the next edge.
REQ-021 A tag freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-022 A response on a non-busy tag, or out_resp=11, SHALL pulse err_spurious and SHALL NOT be pushed.
REQ-023 Each busy tag age counter SHALL increment per cycle and saturate at TIMEOUT.
REQ-024 A saturated tag SHALL push {11, 0, tag} and be freed, at most one timeout push per cycle, only in cycles with no response push, lowest tag first.
REQ-025 If a response and a timeout hit the same tag in one cycle, the response SHALL win.
REQ-026 Result queue: FIFO, head on res_*; res_valid = not empty; pop on res_valid & res_ready.
REQ-027 Simultaneous push and pop SHALL both occur; the queue never overflows because occupancy plus busy tags is at most 4.

Reset
REQ-028 While reset is low: FSM=IDLE, all tags free, counters 0, queue empty.
REQ-029 While reset is low, all outputs SHALL be 0, including op_ready.
REQ-030 A reset asserted mid-issue SHALL abandon the SEND_OP2 cycle; operations in flight are dropped without a result.
REQ-031 op_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-032 Package calc2_pkg SHALL hold: cmd_t enum (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6); resp_t enum (NONE=0, OK=1, ERR=2, TMO=3); TAG_W=2; DATA_W=32.
REQ-033 The result queue SHALL be a sub-module calc2_result_fifo, parameterized by depth and width.
REQ-034 The tag pool and age counters SHALL stay in the top module.

Verification
REQ-035 Accept ADD a=0x22 b=0x3 -> cycle N drives cmd 1, data 0x22, tag 0; N+1 drives cmd 0, data 0x3; response 01/0x25/tag0 -> res {01, 0x25, 0}.
REQ-036 Issue 4 ops with no responses -> tags 0..3 issued on N, N+2, N+4, N+6; op_ready low afterward; response on tag 2 -> next op gets tag 2.
REQ-037 Responses returned out of order (tags 3, 1, 0, 2) with res_ready low, then res_ready high -> results popped in arrival order 3, 1, 0, 2.
REQ-038 No response for 64 cycles on tag 0 -> res {11, 0, 0}; a later response on tag 0 pulses err_spurious and produces no result.
REQ-039 Response on tag 1 while tag 1 is free -> err_spurious pulses for one cycle; queue unchanged.
REQ-040 Reset asserted during SEND_OP2 -> all outputs 0 immediately; after release op_ready=1 and the next op gets tag 0.
